seq_unpack: RTL and testbench

SEQ_UNPACK -- requirements
Module: seq_unpack

---
 rtl/seq_unpack.sv | 131 +++++++++++++
 tb/tb_seq_unpack.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seq_unpack.sv
// Bit-level stream unpacker: 64-bit MSB-first shift buffer fed by packed words, drained by variable-length consumes.
// Optional byte-alignment feature (align_i, pos counter) is enabled by defining UNPACK_ALIGN_EN.
module seq_unpack #(
  parameter int SEQ_IN_WIDTH = 32,
  parameter int PEEK_WIDTH   = 32
) (
  input  logic                    clk_x8_i,
  input  logic                    rst_n_i,
  input  logic [SEQ_IN_WIDTH-1:0] seq_in_i,
  input  logic                    seq_valid_i,
  input  logic                    seq_last_i,
  output logic                    seq_ready_o,
  output logic [PEEK_WIDTH-1:0]   peek_o,
  output logic [6:0]              bits_avail_o,
  input  logic                    consume_i,
  input  logic [4:0]              consume_len_i,
  output logic                    consume_err_o,
  input  logic                    flush_i,
`ifdef UNPACK_ALIGN_EN
  input  logic                    align_i,
`endif
  output logic                    stream_end_o
);

  localparam int         BUF_W     = 64;
  localparam logic [6:0] IN_BITS   = 7'(SEQ_IN_WIDTH);
  localparam logic [6:0] READY_MAX = 7'(BUF_W - SEQ_IN_WIDTH);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } state_t;

  logic [BUF_W-1:0] shift_buf_q;
  logic [6:0]       cnt_q;
  state_t           state_q;
  logic             err_q;

  logic [BUF_W-1:0] buf_shift;
  logic [BUF_W-1:0] buf_next;
  logic [6:0]       len_ext;
  logic [6:0]       shift_len;
  logic [6:0]       cnt_shift;
  logic [6:0]       cnt_next;
  logic             rejected;
  logic             accept;
  state_t           state_next;

`ifdef UNPACK_ALIGN_EN
  logic [2:0] pos_q;
  logic [2:0] pos_next;
  logic [2:0] align_drop;
`endif

  assign seq_ready_o   = (state_q == RUN) && (cnt_q <= READY_MAX);
  assign peek_o        = shift_buf_q[BUF_W-1 -: PEEK_WIDTH];
  assign bits_avail_o  = cnt_q;
  assign consume_err_o = err_q;
  assign stream_end_o  = (state_q == DONE);
  assign accept        = seq_valid_i && seq_ready_o;
  assign len_ext       = {2'b00, consume_len_i};

  // Consume is resolved first; the accepted word then lands right after the surviving bits.
  always_comb begin
    shift_len  = 7'd0;
    rejected   = 1'b0;
`ifdef UNPACK_ALIGN_EN
    align_drop = 3'd0 - pos_q;
`endif
    if (consume_i) begin
      if (len_ext > cnt_q) rejected  = 1'b1;
      else                 shift_len = len_ext;
`ifdef UNPACK_ALIGN_EN
    end else if (align_i) begin
      if ({4'b0000, align_drop} > cnt_q) rejected  = 1'b1;
      else                               shift_len = {4'b0000, align_drop};
`endif
    end

    buf_shift = shift_buf_q << shift_len;
    cnt_shift = cnt_q - shift_len;
    buf_next  = buf_shift;
    cnt_next  = cnt_shift;
    if (accept) begin
      buf_next = buf_shift | ((BUF_W'(seq_in_i) << (BUF_W - SEQ_IN_WIDTH)) >> cnt_shift);
      cnt_next = cnt_shift + IN_BITS;
    end

`ifdef UNPACK_ALIGN_EN
    pos_next = pos_q + shift_len[2:0];
`endif

    state_next = state_q;
    case (state_q)
      RUN:     if (accept && seq_last_i) state_next = DRAIN;
      DRAIN:   if (cnt_next == 7'd0)     state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk_x8_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shift_buf_q <= '0;
      cnt_q       <= 7'd0;
      state_q     <= RUN;
      err_q       <= 1'b0;
`ifdef UNPACK_ALIGN_EN
      pos_q       <= 3'd0;
`endif
    end else if (flush_i) begin
      shift_buf_q <= '0;
      cnt_q       <= 7'd0;
      state_q     <= RUN;
      err_q       <= 1'b0;
`ifdef UNPACK_ALIGN_EN
      pos_q       <= 3'd0;
`endif
    end else begin
      shift_buf_q <= buf_next;
      cnt_q       <= cnt_next;
      state_q     <= state_next;
      err_q       <= rejected;
`ifdef UNPACK_ALIGN_EN
      pos_q       <= pos_next;
`endif
    end
  end

endmodule

// File: tb/tb_seq_unpack.sv
// Directed self-checking bench for seq_unpack; expected values are hand-computed bit positions.
// Align steps are compiled in only when UNPACK_ALIGN_EN is defined.
module tb_seq_unpack;

  logic        clk_x8_i = 1'b0;
  logic        rst_n_i;
  logic [31:0] seq_in_i;
  logic        seq_valid_i;
  logic        seq_last_i;
  logic        seq_ready_o;
  logic [31:0] peek_o;
  logic [6:0]  bits_avail_o;
  logic        consume_i;
  logic [4:0]  consume_len_i;
  logic        consume_err_o;
  logic        flush_i;
  logic        stream_end_o;
`ifdef UNPACK_ALIGN_EN
  logic        align_i;
`endif

  int pass_count  = 0;
  int check_count = 0;

  always #5 clk_x8_i = ~clk_x8_i;

  seq_unpack #(.SEQ_IN_WIDTH(32), .PEEK_WIDTH(32)) dut (
    .clk_x8_i      (clk_x8_i),
    .rst_n_i       (rst_n_i),
    .seq_in_i      (seq_in_i),
    .seq_valid_i   (seq_valid_i),
    .seq_last_i    (seq_last_i),
    .seq_ready_o   (seq_ready_o),
    .peek_o        (peek_o),
    .bits_avail_o  (bits_avail_o),
    .consume_i     (consume_i),
    .consume_len_i (consume_len_i),
    .consume_err_o (consume_err_o),
    .flush_i       (flush_i),
`ifdef UNPACK_ALIGN_EN
    .align_i       (align_i),
`endif
    .stream_end_o  (stream_end_o)
  );

  task automatic clearInputs();
    seq_in_i      = '0;
    seq_valid_i   = 1'b0;
    seq_last_i    = 1'b0;
    consume_i     = 1'b0;
    consume_len_i = '0;
    flush_i       = 1'b0;
`ifdef UNPACK_ALIGN_EN
    align_i       = 1'b0;
`endif
  endtask

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus(input logic valid, input logic [31:0] word, input logic last,
                               input logic cons, input logic [4:0] len, input logic flush);
    seq_valid_i   = valid;
    seq_in_i      = word;
    seq_last_i    = last;
    consume_i     = cons;
    consume_len_i = len;
    flush_i       = flush;
    @(posedge clk_x8_i);
    #1;
    clearInputs();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected) begin
      pass_count++;
    end else begin
      $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    clearInputs();
    rst_n_i = 1'b0;
    repeat (2) @(posedge clk_x8_i);
    #1;
    checkOutput("rst_peek",  peek_o, 32'h0);
    checkOutput("rst_avail", 32'(bits_avail_o), 32'd0);
    checkOutput("rst_err",   32'(consume_err_o), 32'd0);
    checkOutput("rst_end",   32'(stream_end_o), 32'd0);
    checkOutput("rst_ready", 32'(seq_ready_o), 32'd1);
    @(negedge clk_x8_i);
    rst_n_i = 1'b1;
    @(posedge clk_x8_i);
    #1;

    applyStimulus(1'b1, 32'hA5A5_0000, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("acc_avail", 32'(bits_avail_o), 32'd32);
    checkOutput("acc_peek",  peek_o, 32'hA5A5_0000);
    checkOutput("acc_ready", 32'(seq_ready_o), 32'd1);

    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 5'd4, 1'b0);
    checkOutput("c4_peek",  peek_o, 32'h5A50_0000);
    checkOutput("c4_avail", 32'(bits_avail_o), 32'd28);
    checkOutput("c4_err",   32'(consume_err_o), 32'd0);

    // Consume 12 of the remaining 28 bits leaves 16 zero bits, then the word lands at position 16.
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd12, 1'b0);
    checkOutput("cacc_avail", 32'(bits_avail_o), 32'd48);
    checkOutput("cacc_peek",  peek_o, 32'h0000_FFFF);
    checkOutput("cacc_ready", 32'(seq_ready_o), 32'd0);

    applyStimulus(1'b1, 32'h1234_5678, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("notready_avail", 32'(bits_avail_o), 32'd48);
    checkOutput("notready_peek",  peek_o, 32'h0000_FFFF);

    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 5'd31, 1'b0);
    checkOutput("c31_avail", 32'(bits_avail_o), 32'd17);
    checkOutput("c31_peek",  peek_o, 32'hFFFF_8000);

    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 5'd14, 1'b0);
    checkOutput("c14_avail", 32'(bits_avail_o), 32'd3);
    checkOutput("c14_peek",  peek_o, 32'hE000_0000);

    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 5'd5, 1'b0);
    checkOutput("rej_err",   32'(consume_err_o), 32'd1);
    checkOutput("rej_avail", 32'(bits_avail_o), 32'd3);
    checkOutput("rej_peek",  peek_o, 32'hE000_0000);

    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 5'd0, 1'b0);
    checkOutput("zero_err",   32'(consume_err_o), 32'd0);
    checkOutput("zero_avail", 32'(bits_avail_o), 32'd3);

    // Flush beats a same-cycle accept and an oversize consume.
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 5'd20, 1'b1);
    checkOutput("flush_avail", 32'(bits_avail_o), 32'd0);
    checkOutput("flush_peek",  peek_o, 32'h0);
    checkOutput("flush_err",   32'(consume_err_o), 32'd0);
    checkOutput("flush_ready", 32'(seq_ready_o), 32'd1);

    applyStimulus(1'b1, 32'h1234_5678, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("last_ready", 32'(seq_ready_o), 32'd0);
    checkOutput("last_avail", 32'(bits_avail_o), 32'd32);
    checkOutput("last_end",   32'(stream_end_o), 32'd0);

    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 5'd16, 1'b0);
    checkOutput("drain_peek", peek_o, 32'h5678_0000);
    checkOutput("drain_end",  32'(stream_end_o), 32'd0);

    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 5'd16, 1'b0);
    checkOutput("done_avail", 32'(bits_avail_o), 32'd0);
    checkOutput("done_end",   32'(stream_end_o), 32'd1);
    checkOutput("done_ready", 32'(seq_ready_o), 32'd0);

    applyStimulus(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("done_noacc", 32'(bits_avail_o), 32'd0);
    checkOutput("done_hold",  32'(stream_end_o), 32'd1);

    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
    checkOutput("restart_end",   32'(stream_end_o), 32'd0);
    checkOutput("restart_ready", 32'(seq_ready_o), 32'd1);
    checkOutput("restart_avail", 32'(bits_avail_o), 32'd0);

`ifdef UNPACK_ALIGN_EN
    applyStimulus(1'b1, 32'hFFFF_0000, 1'b0, 1'b1, 5'd0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 5'd3, 1'b0);
    checkOutput("al_c3_avail", 32'(bits_avail_o), 32'd29);
    align_i = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("al1_avail", 32'(bits_avail_o), 32'd24);
    checkOutput("al1_peek",  peek_o, 32'hFF00_0000);
    checkOutput("al1_err",   32'(consume_err_o), 32'd0);
    align_i = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("al2_avail", 32'(bits_avail_o), 32'd24);
    checkOutput("al2_err",   32'(consume_err_o), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
`endif

    // Asynchronous reset in the middle of a stream drops everything at once.
    applyStimulus(1'b1, 32'h8765_4321, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("pre_rst_avail", 32'(bits_avail_o), 32'd32);
    rst_n_i = 1'b0;
    #1;
    checkOutput("mid_rst_avail", 32'(bits_avail_o), 32'd0);
    checkOutput("mid_rst_peek",  peek_o, 32'h0);
    checkOutput("mid_rst_ready", 32'(seq_ready_o), 32'd1);
    @(negedge clk_x8_i);
    rst_n_i = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 5'd1, 1'b0);
    checkOutput("post_rst_err", 32'(consume_err_o), 32'd1);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
